// File: rtl/tdc_spi_pkg.sv
// tdc_spi_pkg: shared constants and types for the TDC SPI responder.
// Register map, reset values, FSM states and width helper.
package tdc_spi_pkg;

  localparam logic [5:0] ADDR_CONFIG1     = 6'h00;
  localparam logic [5:0] ADDR_CONFIG2     = 6'h01;
  localparam logic [5:0] ADDR_INT_STATUS  = 6'h02;
  localparam logic [5:0] ADDR_INT_MASK    = 6'h03;
  localparam logic [5:0] ADDR_COARSE_H    = 6'h04;
  localparam logic [5:0] ADDR_COARSE_L    = 6'h05;
  localparam logic [5:0] ADDR_CLOCK_H     = 6'h06;
  localparam logic [5:0] ADDR_CLOCK_L     = 6'h07;
  localparam logic [5:0] ADDR_STOP_H      = 6'h08;
  localparam logic [5:0] ADDR_STOP_L      = 6'h09;

  localparam logic [5:0] REG24_BASE       = 6'h10;
  localparam logic [5:0] REG24_LAST       = 6'h1B;
  localparam int         NUM_MEAS         = 12;

  localparam logic [7:0] RST_CONFIG1      = 8'h00;
  localparam logic [7:0] RST_CONFIG2      = 8'h40;
  localparam logic [7:0] RST_INT_MASK     = 8'h07;
  localparam logic [7:0] RST_OVF          = 8'hFF;
  localparam logic [7:0] RST_STOP_MASK    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN
  } spi_state_t;

  function automatic logic [4:0] reg_width(
    input logic [5:0] a
  );
    if (a >= REG24_BASE && a <= REG24_LAST)
      return 5'd24;
    return 5'd8;
  endfunction

endpackage

// File: rtl/tdc_spi_responder_sync.sv
// spi_edge_sync: two-flop synchronizer for one SPI pad,
// followed by a registered rise/fall detect stage.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Resynchronize the pad and register its edges alongside the level
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_pad;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/tdc_spi_responder.sv
// tdc_spi_responder: SPI slave emulating a TDC7200-class register map,
// with parallel result loading and TDC-style interrupt generation.
module tdc_spi_responder
  import tdc_spi_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        csb,
  input  logic        sclk,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic        meas_load,
  input  logic [3:0]  meas_idx,
  input  logic [23:0] meas_data,
  input  logic        meas_done,
  output logic        meas_start,
  output logic [7:0]  cfg_config1,
  output logic [7:0]  cfg_config2,
  output logic        intb
);

  logic w_csb_lvl;
  logic w_csb_rise;
  logic w_csb_fall;
  logic w_sclk_lvl;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_sdi_lvl;
  logic w_sdi_rise;
  logic w_sdi_fall;
  logic w_unused;

  spi_edge_sync #(.RST_VAL(1'b1)) u_sync_csb (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_pad   (csb),
    .o_level (w_csb_lvl),
    .o_rise  (w_csb_rise),
    .o_fall  (w_csb_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_pad   (sclk),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_sync_sdi (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_pad   (sdi),
    .o_level (w_sdi_lvl),
    .o_rise  (w_sdi_rise),
    .o_fall  (w_sdi_fall)
  );

  assign w_unused = ^{w_csb_rise, w_csb_fall, w_sclk_lvl,
                      w_sdi_rise, w_sdi_fall};

  spi_state_t  r_state;
  spi_state_t  w_state_nxt;
  logic [4:0]  r_bitcnt;
  logic [23:0] r_shift;
  logic [5:0]  r_addr;
  logic        r_autoinc;
  logic        r_rw;
  logic        r_sdo;

  logic [7:0]  r_config1;
  logic [7:0]  r_config2;
  logic        r_int_status;
  logic [7:0]  r_int_mask;
  logic [7:0]  r_coarse_h;
  logic [7:0]  r_coarse_l;
  logic [7:0]  r_clock_h;
  logic [7:0]  r_clock_l;
  logic [7:0]  r_stop_h;
  logic [7:0]  r_stop_l;
  logic [23:0] r_meas [0:NUM_MEAS-1];
  logic        r_meas_start;
  logic        r_intb;

  logic        w_active;
  logic [4:0]  w_width;
  logic        w_cmd_last;
  logic        w_data_last;
  logic        w_wr_en;
  logic [7:0]  w_wr_data;
  logic        w_sdo_bit;
  logic [5:0]  w_rd_addr;
  logic [23:0] w_rd_data;
  logic        w_int_nxt;
  logic [7:0]  w_mask_nxt;

  assign w_active    = ~w_csb_lvl;
  assign w_width     = reg_width(r_addr);
  assign w_cmd_last  = w_active && (r_state == ST_CMD) &&
                       w_sclk_rise && (r_bitcnt == 5'd7);
  assign w_data_last = w_active && (r_state == ST_DATA) &&
                       w_sclk_rise && (r_bitcnt == w_width - 5'd1);
  assign w_wr_en     = w_data_last && r_rw;
  assign w_wr_data   = {r_shift[6:0], w_sdi_lvl};
  assign w_sdo_bit   = (w_width == 5'd24) ? r_shift[23] : r_shift[7];

  // Address whose contents get loaded at the next data-phase start
  always_comb begin
    w_rd_addr = r_addr + 6'd1;
    if (r_state == ST_CMD)
      w_rd_addr = {r_shift[4:0], w_sdi_lvl};
  end

  // Register read mux; unmapped addresses return zero
  always_comb begin
    w_rd_data = '0;
    if (w_rd_addr >= REG24_BASE && w_rd_addr <= REG24_LAST) begin
      w_rd_data = r_meas[w_rd_addr[3:0]];
    end else begin
      case (w_rd_addr)
        ADDR_CONFIG1:    w_rd_data = {16'd0, r_config1};
        ADDR_CONFIG2:    w_rd_data = {16'd0, r_config2};
        ADDR_INT_STATUS: w_rd_data = {23'd0, r_int_status};
        ADDR_INT_MASK:   w_rd_data = {16'd0, r_int_mask};
        ADDR_COARSE_H:   w_rd_data = {16'd0, r_coarse_h};
        ADDR_COARSE_L:   w_rd_data = {16'd0, r_coarse_l};
        ADDR_CLOCK_H:    w_rd_data = {16'd0, r_clock_h};
        ADDR_CLOCK_L:    w_rd_data = {16'd0, r_clock_l};
        ADDR_STOP_H:     w_rd_data = {16'd0, r_stop_h};
        ADDR_STOP_L:     w_rd_data = {16'd0, r_stop_l};
        default:         w_rd_data = '0;
      endcase
    end
  end

  // Frame sequencing; deasserted chip select always returns to idle
  always_comb begin
    w_state_nxt = r_state;
    if (!w_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  w_state_nxt = ST_CMD;
        ST_CMD:   if (w_cmd_last) w_state_nxt = ST_DATA;
        ST_DATA:  if (w_data_last && !r_autoinc) w_state_nxt = ST_DRAIN;
        ST_DRAIN: w_state_nxt = ST_DRAIN;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Shift register, bit counter, command latch and serial output
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_autoinc <= 1'b0;
      r_rw      <= 1'b0;
      r_sdo     <= 1'b0;
    end else begin
      if (!w_active || r_state == ST_IDLE) begin
        r_bitcnt <= '0;
      end else if (w_cmd_last) begin
        r_autoinc <= r_shift[6];
        r_rw      <= r_shift[5];
        r_addr    <= w_rd_addr;
        r_shift   <= w_rd_data;
        r_bitcnt  <= '0;
      end else if (w_data_last) begin
        r_bitcnt <= '0;
        if (r_autoinc) begin
          r_addr  <= w_rd_addr;
          r_shift <= w_rd_data;
        end
      end else if (w_sclk_rise &&
                   (r_state == ST_CMD || r_state == ST_DATA)) begin
        r_shift  <= {r_shift[22:0], w_sdi_lvl};
        r_bitcnt <= r_bitcnt + 5'd1;
      end
      if (w_active && r_state == ST_DATA) begin
        if (w_sclk_fall) r_sdo <= w_sdo_bit;
      end else begin
        r_sdo <= 1'b0;
      end
    end
  end

  // Interrupt status and mask next values; a completion beats a clear
  always_comb begin
    w_int_nxt  = r_int_status;
    w_mask_nxt = r_int_mask;
    if (w_wr_en && r_addr == ADDR_INT_STATUS && w_wr_data[0])
      w_int_nxt = 1'b0;
    if (meas_done)
      w_int_nxt = 1'b1;
    if (w_wr_en && r_addr == ADDR_INT_MASK)
      w_mask_nxt = w_wr_data;
  end

  // Configuration registers, start pulse and interrupt output
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_config1    <= RST_CONFIG1;
      r_config2    <= RST_CONFIG2;
      r_int_status <= 1'b0;
      r_int_mask   <= RST_INT_MASK;
      r_coarse_h   <= RST_OVF;
      r_coarse_l   <= RST_OVF;
      r_clock_h    <= RST_OVF;
      r_clock_l    <= RST_OVF;
      r_stop_h     <= RST_STOP_MASK;
      r_stop_l     <= RST_STOP_MASK;
      r_meas_start <= 1'b0;
      r_intb       <= 1'b1;
    end else begin
      r_meas_start <= w_wr_en && (r_addr == ADDR_CONFIG1) &&
                      w_wr_data[0];
      if (w_wr_en) begin
        case (r_addr)
          ADDR_CONFIG1:  r_config1  <= w_wr_data;
          ADDR_CONFIG2:  r_config2  <= w_wr_data;
          ADDR_COARSE_H: r_coarse_h <= w_wr_data;
          ADDR_COARSE_L: r_coarse_l <= w_wr_data;
          ADDR_CLOCK_H:  r_clock_h  <= w_wr_data;
          ADDR_CLOCK_L:  r_clock_l  <= w_wr_data;
          ADDR_STOP_H:   r_stop_h   <= w_wr_data;
          ADDR_STOP_L:   r_stop_l   <= w_wr_data;
          default:       ;
        endcase
      end
      if (meas_done) r_config1[0] <= 1'b0;
      r_int_status <= w_int_nxt;
      r_int_mask   <= w_mask_nxt;
      r_intb       <= ~(w_int_nxt & w_mask_nxt[0]);
    end
  end

  // Measurement result registers, loaded from the parallel port
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MEAS; i++) r_meas[i] <= '0;
    end else if (meas_load && meas_idx < 4'd12) begin
      r_meas[meas_idx] <= meas_data;
    end
  end

  assign sdo         = r_sdo;
  assign sdo_oe      = w_active;
  assign meas_start  = r_meas_start;
  assign cfg_config1 = r_config1;
  assign cfg_config2 = r_config2;
  assign intb        = r_intb;

endmodule

// File: tb/tb_tdc_spi_responder.sv
// tb_tdc_spi_responder: directed and random SPI frames against
// a register-map level model of the TDC responder.
module tb_tdc_spi_responder;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        csb = 1'b1;
  logic        sclk = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        sdo_oe;
  logic        meas_load = 1'b0;
  logic [3:0]  meas_idx = '0;
  logic [23:0] meas_data = '0;
  logic        meas_done = 1'b0;
  logic        meas_start;
  logic [7:0]  cfg_config1;
  logic [7:0]  cfg_config2;
  logic        intb;

  tdc_spi_responder dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .csb         (csb),
    .sclk        (sclk),
    .sdi         (sdi),
    .sdo         (sdo),
    .sdo_oe      (sdo_oe),
    .meas_load   (meas_load),
    .meas_idx    (meas_idx),
    .meas_data   (meas_data),
    .meas_done   (meas_done),
    .meas_start  (meas_start),
    .cfg_config1 (cfg_config1),
    .cfg_config2 (cfg_config2),
    .intb        (intb)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_starts = 0;
  int seen_starts = 0;

  logic [7:0]  m_cfg  [0:9];
  logic [23:0] m_meas [0:11];
  logic        m_int;

  bit          tx_q [$];
  bit          rx_q [$];
  logic [23:0] wv_q [$];

  always @(posedge clock)
    if (rst_n && meas_start) seen_starts <= seen_starts + 1;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_width(input int a);
    return (a >= 16 && a <= 27) ? 24 : 8;
  endfunction

  function automatic logic [23:0] m_read(input int a);
    if (a == 2) return {23'd0, m_int};
    if (a < 10) return {16'd0, m_cfg[a]};
    if (a >= 16 && a <= 27) return m_meas[a-16];
    return 24'd0;
  endfunction

  task automatic m_write(input int a, input logic [23:0] v);
    if (a == 0) begin
      m_cfg[0] = v[7:0];
      if (v[0]) exp_starts++;
    end else if (a == 2) begin
      if (v[0]) m_int = 1'b0;
    end else if (a < 10) begin
      m_cfg[a] = v[7:0];
    end
  endtask

  task automatic m_done();
    m_int = 1'b1;
    m_cfg[0][0] = 1'b0;
  endtask

  task automatic push_bits(input logic [23:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endtask

  task automatic spi_run(input int hook);
    int n;
    n = tx_q.size();
    rx_q.delete();
    csb = 1'b0;
    for (int i = 0; i < n; i++) begin
      sdi = tx_q[i];
      repeat (HALF) @(negedge clock);
      if (i == 0) chk("sdo_oe", {47'd0, sdo_oe}, 48'd1);
      rx_q.push_back(sdo);
      sclk = 1'b1;
      if (i == hook) begin
        repeat (3) @(negedge clock);
        meas_done = 1'b1;
        @(negedge clock);
        meas_done = 1'b0;
        repeat (HALF - 4) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clock);
    csb = 1'b1;
    sdi = 1'b0;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic do_read(input logic [5:0] a, input bit ai,
                         input int nregs, input int extra);
    logic [23:0] exp [$];
    int          wid [$];
    logic [5:0]  ea;
    logic [23:0] v;
    logic [7:0]  c;
    int          pos;
    tx_q.delete();
    push_bits({16'd0, ai, 1'b0, a}, 8);
    for (int k = 0; k < nregs; k++) begin
      ea = a + 6'(k);
      wid.push_back(m_width(int'(ea)));
      exp.push_back(m_read(int'(ea)));
      push_bits(24'd0, m_width(int'(ea)));
    end
    for (int k = 0; k < extra; k++) tx_q.push_back(1'b0);
    spi_run(-1);
    c = '0;
    for (int i = 0; i < 8; i++) c = {c[6:0], rx_q[i]};
    chk("cmd_phase_sdo", {40'd0, c}, 48'd0);
    pos = 8;
    for (int k = 0; k < nregs; k++) begin
      v = '0;
      for (int b = 0; b < wid[k]; b++) begin
        v = {v[22:0], rx_q[pos]};
        pos++;
      end
      ea = a + 6'(k);
      chk($sformatf("rd_%02h", ea), {24'd0, v}, {24'd0, exp[k]});
    end
    if (extra > 0) begin
      v = '0;
      for (int b = 0; b < extra; b++) begin
        v = {v[22:0], rx_q[pos]};
        pos++;
      end
      chk("drain_sdo", {24'd0, v}, 48'd0);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input bit ai,
                          input int nregs, input bit hook);
    logic [5:0] ea;
    tx_q.delete();
    push_bits({16'd0, ai, 1'b1, a}, 8);
    for (int k = 0; k < nregs; k++) begin
      ea = a + 6'(k);
      push_bits(wv_q[k], m_width(int'(ea)));
    end
    spi_run(hook ? tx_q.size() - 1 : -1);
    for (int k = 0; k < nregs; k++) begin
      ea = a + 6'(k);
      if (k == 0 || ai) m_write(int'(ea), wv_q[k]);
    end
    if (hook) m_done();
  endtask

  task automatic load_meas(input logic [3:0] idx, input logic [23:0] d);
    meas_idx  = idx;
    meas_data = d;
    meas_load = 1'b1;
    @(negedge clock);
    meas_load = 1'b0;
    if (idx < 12) m_meas[idx] = d;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_done();
    meas_done = 1'b1;
    @(negedge clock);
    meas_done = 1'b0;
    m_done();
    repeat (3) @(negedge clock);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_cfg1"}, {40'd0, cfg_config1}, {40'd0, m_cfg[0]});
    chk({tag, "_cfg2"}, {40'd0, cfg_config2}, {40'd0, m_cfg[1]});
    chk({tag, "_intb"}, {47'd0, intb},
        {47'd0, ~(m_int & m_cfg[3][0])});
    chk({tag, "_starts"}, 48'(seen_starts), 48'(exp_starts));
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [5:0] a;
    bit ai;
    int n;
    m_cfg[0] = 8'h00; m_cfg[1] = 8'h40; m_cfg[2] = 8'h00;
    m_cfg[3] = 8'h07;
    for (int i = 4; i < 8; i++) m_cfg[i] = 8'hFF;
    m_cfg[8] = 8'h00; m_cfg[9] = 8'h00;
    for (int i = 0; i < 12; i++) m_meas[i] = '0;
    m_int = 1'b0;

    repeat (5) @(negedge clock);
    rst_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("rst_sdo", {47'd0, sdo}, 48'd0);
    chk("rst_sdo_oe", {47'd0, sdo_oe}, 48'd0);
    chk("rst_start", {47'd0, meas_start}, 48'd0);
    check_outs("rst");
    do_read(6'h03, 1'b0, 1, 8);

    wv_q = '{24'h01};
    do_write(6'h00, 1'b0, 1, 1'b0);
    check_outs("wr_cfg1");
    do_read(6'h00, 1'b0, 1, 0);

    load_meas(4'd0, 24'h123456);
    pulse_done();
    check_outs("done");
    do_read(6'h10, 1'b0, 1, 0);
    wv_q = '{24'h01};
    do_write(6'h02, 1'b0, 1, 1'b0);
    check_outs("clr");

    do_read(6'h04, 1'b1, 6, 0);
    load_meas(4'd11, 24'hABCDEF);
    load_meas(4'd13, 24'h777777);
    do_read(6'h1B, 1'b1, 2, 0);

    tx_q.delete();
    push_bits(24'h41, 8);
    push_bits(24'h1F, 5);
    spi_run(-1);
    check_outs("abort");

    wv_q = '{24'h01};
    do_write(6'h02, 1'b0, 1, 1'b1);
    check_outs("setwins");
    do_read(6'h02, 1'b0, 1, 0);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          a  = 6'($urandom_range(0, 31));
          ai = 1'($urandom_range(0, 1));
          n  = ai ? $urandom_range(1, 2) : 1;
          wv_q.delete();
          for (int k = 0; k < n; k++) wv_q.push_back(24'($urandom));
          do_write(a, ai, n, 1'b0);
        end
        1: begin
          a  = 6'($urandom_range(0, 63));
          ai = 1'($urandom_range(0, 1));
          n  = ai ? $urandom_range(1, 3) : 1;
          do_read(a, ai, n, 0);
        end
        2: load_meas(4'($urandom_range(0, 15)), 24'($urandom));
        default: pulse_done();
      endcase
      check_outs($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_spi_responder.md
# tdc_spi_responder

SPI responder that emulates the register map of one TDC7200-class time-to-digital converter, i.e. the far end of the TDC SPI links (`csb0/1`, `sclk0/1`, `dout0/1` → TDC, `din0/1` ← TDC) driven by the CEMF controller. It holds the ten 8-bit configuration registers and twelve 24-bit measurement registers. Measurement values come in over a parallel load port, and `intb` is generated the same way the TDC does it. It is used both as an FPGA-in-the-loop stand-in for the TDC chips and as the bench model for verifying the controller's configure/operate/read sequences.

## Interface
- No parameters.
- `clock`  in  1  system clock; must be ≥ 8× SCLK frequency
- `rst_n`  in  1  reset, asynchronous, active-low
- `csb`  in  1  SPI chip select, active-low, asynchronous to `clock`
- `sclk`  in  1  SPI clock, mode 0, asynchronous to `clock`
- `sdi`  in  1  serial data from controller (controller `dout`)
- `sdo`  out  1  serial data to controller (controller `din`)
- `sdo_oe`  out  1  high while `csb` (synchronized) low
- `meas_load`  in  1  one-cycle strobe: write `meas_data` into result register `0x10 + meas_idx`
- `meas_idx`  in  4  result index 0..11; values 12..15 are ignored
- `meas_data`  in  24  result value
- `meas_done`  in  1  one-cycle strobe: measurement complete
- `meas_start`  out  1  one-cycle pulse when an SPI write sets CONFIG1[0]
- `cfg_config1`  out  8  current CONFIG1
- `cfg_config2`  out  8  current CONFIG2
- `intb`  out  1  interrupt, active-low

## Operation
- Frame: `csb` falls, then an 8-bit command, then data, all MSB first. Command: [7] AUTOINC, [6] RW (1 = write), [5:0] address.
- Register map:
  - 0x00 CONFIG1, reset 0x00
  - 0x01 CONFIG2, reset 0x40
  - 0x02 INT_STATUS, reset 0x00
  - 0x03 INT_MASK, reset 0x07
  - 0x04/0x05 COARSE_CNTR_OVF H/L, reset 0xFF
  - 0x06/0x07 CLOCK_CNTR_OVF H/L, reset 0xFF
  - 0x08/0x09 CLOCK_CNTR_STOP_MASK H/L, reset 0x00
  - 0x10–0x1B TIME1..CALIBRATION2, 24-bit, read-only, reset 0
- Data width: 24 bits for 0x10–0x1B, 8 bits elsewhere. Unmapped addresses read 0 (8-bit) and ignore writes.
- Write: the register updates only after its last data bit is sampled. If `csb` rises before then, the partial byte is discarded.
- Read: the whole register is copied into the shift register at the start of its data phase. A later `meas_load` to the same register does not disturb the value being shifted out.
- AUTOINC=1: after each register's data phase the address increments modulo 64 and the next register's phase begins. AUTOINC=0: after the first register, `sdo`=0 and writes are ignored until `csb` rises.
- INT_STATUS[0] NEW_MEAS_INT is set by `meas_done`. It is cleared by an SPI write with bit0=1; bits [7:1] read 0. When `meas_done` and the clear land in the same cycle, set wins.
- `intb` = ~(INT_STATUS[0] & INT_MASK[0]).
- CONFIG1[0] START_MEAS:
  - A write with bit0=1 sets it and pulses `meas_start` once.
  - It stays 1 until `meas_done`, which clears it.
  - A write of 0 clears it with no pulse.
- FSM, all states forced to IDLE whenever synchronized `csb`=1:
  - IDLE: `csb` falls → CMD with bit counter = 0.
  - CMD: after the 8th sampled bit, latch the command → DATA.
  - DATA: on the last bit of the register's width, commit the write or advance the address, then stay in DATA (AUTOINC) or go to DRAIN.
  - DRAIN: ignore all bits until `csb` rises.

## Timing
- `csb`, `sclk` and `sdi` each pass through a 2-flop synchronizer plus one edge-detect stage. Edges are therefore seen 3 `clock` cycles after the pad.
- `sdi` is sampled on detected SCLK rise.
- `sdo` shifts on detected SCLK fall. It is registered, so it changes ≤4 `clock` cycles after the pad fall.
- Data MSB appears on the SCLK fall that follows the 8th command rise. `sdo`=0 throughout the command phase.
- Write commit, `meas_start` and the INT_STATUS update all occur 1 cycle after the detected rise of the final bit.
- `intb` is registered: 1 cycle after `meas_done`, and 1 cycle after the clearing write commits.
- `meas_load` takes effect the following cycle.
- Reset values: `sdo`=0, `sdo_oe`=0, `intb`=1, `meas_start`=0, `cfg_config1`=0x00, `cfg_config2`=0x40, FSM in IDLE, all registers at their reset values. Reset asserted mid-frame aborts the frame immediately.

## Structure
- Package `tdc_spi_pkg`:
  - register address constants
  - reset-value constants
  - FSM state enum
  - `REG24_BASE`=0x10 and `REG24_LAST`=0x1B
  - helper that returns the data width for an address
- Sub-module `spi_edge_sync`, one instance per input (`csb`, `sclk`, `sdi`): synchronizer and rise/fall detect.
- Top level contains the FSM, 5-bit bit counter, 24-bit shift register and the register file.

## Test plan
- Reset: after reset, with no SPI traffic, `intb`=1, `cfg_config2`=0x40, and a read of 0x03 returns 0x07.
- Single write: write 0x01 to address 0x00 → `cfg_config1`=0x01, one `meas_start` pulse. A subsequent read returns 0x01.
- Measurement and interrupt: `meas_load` idx 0 with 0x123456, then `meas_done` → `intb`=0 and CONFIG1[0] clears. Read of 0x10 returns 0x123456. Writing 0x01 to 0x02 → `intb`=1.
- Auto-increment across the map: AUTOINC read of 0x04 for 48 bits → 0xFF,0xFF,0xFF,0xFF,0x00,0x00. AUTOINC read of 0x1B → 24-bit value, then wrap to 0x1C returns 0x00.
- Aborted write: `csb` rises after 5 data bits of a write to 0x01 → CONFIG2 remains 0x40.
- Set wins: `meas_done` in the same cycle as a clearing write's commit → INT_STATUS[0]=1, `intb`=0.
